seg_scan_driver: RTL

Time-multiplexed driver for the two 4-digit seven-segment groups on the board. It sits directly downstream of the device port. The CPU writes a 32-bit hex value and an 8-bit decimal-point mask. The driver holds that write in a shadow register, commits it to the display only at a frame boundary so a frame never shows mixed data, and scans both groups in parallel with a prescaled digit counter.

---
 rtl/seg_scan_driver_pkg.sv | 18 +
 rtl/seg_scan_driver_if.sv | 20 ++
 rtl/seg_hex_decode.sv | 15 +
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver shared constants: segment patterns and group geometry.
// Used by the top, the hex decoder and the write-port interface users.
package seg_scan_driver_pkg;

  localparam int DIGITS = 4;
  localparam int DP_BIT = 7;

  localparam logic [6:0] BLANK = 7'h00;

  // Index is the nibble value; bits are {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// CPU-side write port of seg_scan_driver.
// master drives writes; slave reports the pending flag.
interface seg_scan_driver_if;

  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic        pending;

  modport master (
    output wr_en, wr_data, wr_dp,
    input  pending
  );

  modport slave (
    input  wr_en, wr_data, wr_dp,
    output pending
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment pattern {g,f,e,d,c,b,a}.
// One instance per display group.
module seg_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = BLANK;
    o_seg = SEG_HEX[i_nib];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-group multiplexed 7-seg driver with frame-aligned shadow commit.
// Optional leading-zero blanking: define SEG_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus,
  output logic [3:0]       seg0_cs,
  output logic [7:0]       seg0_data,
  output logic [3:0]       seg1_cs,
  output logic [7:0]       seg1_data
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [31:0]   r_sh_val;
  logic [7:0]    r_sh_dp;
  logic [31:0]   r_dv_val;
  logic [7:0]    r_dv_dp;
  logic          r_pend;
  logic [3:0]    r_cs;
  logic [7:0]    r_d0;
  logic [7:0]    r_d1;

  logic       w_tick;
  logic       w_frame;
  logic [3:0] w_nib0;
  logic [3:0] w_nib1;
  logic [6:0] w_pat0;
  logic [6:0] w_pat1;
  logic       w_dp0;
  logic       w_dp1;
  logic       w_blank0;
  logic       w_blank1;

  assign w_tick  = (r_div == DW'(SCAN_DIV - 1));
  assign w_frame = w_tick && (r_idx == 2'd3);

  // Group 0 holds the upper word half, group 1 the lower
  assign w_nib0 = r_dv_val[{1'b1, r_idx, 2'b00} +: 4];
  assign w_nib1 = r_dv_val[{1'b0, r_idx, 2'b00} +: 4];
  assign w_dp0  = r_dv_dp[{1'b1, r_idx}];
  assign w_dp1  = r_dv_dp[{1'b0, r_idx}];

  seg_hex_decode u_dec0 (
    .i_nib (w_nib0),
    .o_seg (w_pat0)
  );

  seg_hex_decode u_dec1 (
    .i_nib (w_nib1),
    .o_seg (w_pat1)
  );

`ifdef SEG_ZERO_BLANK_EN
  logic [3:0] w_nz0;
  logic [3:0] w_nz1;

  always_comb begin
    w_nz0 = '0;
    w_nz1 = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_nz0[i] = |r_dv_val[16+4*i +: 4];
      w_nz1[i] = |r_dv_val[4*i +: 4];
    end
  end

  // Blank when this digit and every higher one in the group is zero
  assign w_blank0 = (r_idx != 2'd0) && ((w_nz0 >> r_idx) == 4'd0);
  assign w_blank1 = (r_idx != 2'd0) && ((w_nz1 >> r_idx) == 4'd0);
`else
  assign w_blank0 = 1'b0;
  assign w_blank1 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div    <= '0;
      r_idx    <= '0;
      r_sh_val <= '0;
      r_sh_dp  <= '0;
      r_dv_val <= '0;
      r_dv_dp  <= '0;
      r_pend   <= 1'b0;
      r_cs     <= '0;
      r_d0     <= '0;
      r_d1     <= '0;
    end else begin
      if (w_tick) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      // Commit uses the pre-edge shadow, so a colliding write waits a frame
      if (w_frame && r_pend) begin
        r_dv_val <= r_sh_val;
        r_dv_dp  <= r_sh_dp;
      end
      if (bus.wr_en) begin
        r_sh_val <= bus.wr_data;
        r_sh_dp  <= bus.wr_dp;
        r_pend   <= 1'b1;
      end else if (w_frame) begin
        r_pend   <= 1'b0;
      end
      r_cs <= 4'b0001 << r_idx;
      r_d0 <= {w_dp0, w_blank0 ? BLANK : w_pat0};
      r_d1 <= {w_dp1, w_blank1 ? BLANK : w_pat1};
    end
  end

  assign bus.pending = r_pend;
  assign seg0_cs     = r_cs;
  assign seg1_cs     = r_cs;
  assign seg0_data   = r_d0;
  assign seg1_data   = r_d1;

endmodule
